// File: rtl/frame_monitor.sv
// Receive-side frame checker: delimits frames on rx_dv, validates XOR checksum and
// length limits, and keeps good/error counters behind a small register bus.
module frame_monitor #(
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter int unsigned MIN_LEN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        bus_cmd_valid,
    input  logic        bus_op,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wr_data,
    output logic [15:0] bus_rd_data,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_e;

    localparam logic [15:0] OFF_FRAME_CNT = 16'd0;
    localparam logic [15:0] OFF_ERR_CNT   = 16'd1;
    localparam logic [15:0] OFF_LAST_LEN  = 16'd2;
    localparam logic [15:0] OFF_MAX_LEN   = 16'd3;
    localparam logic [15:0] OFF_CTRL      = 16'd4;
    localparam logic [15:0] MIN_LEN_W     = 16'(MIN_LEN);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  xor_q, xor_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] last_len_q, last_len_d;
    logic [15:0] max_len_q, max_len_d;
    logic        en_q, en_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        wr_en;
    logic        rd_en;
    logic [15:0] reg_off;
    logic        frame_bad;

    assign wr_en     = bus_cmd_valid & bus_op;
    assign rd_en     = bus_cmd_valid & ~bus_op;
    assign reg_off   = bus_addr - BASE_ADDR;
    assign frame_bad = (xor_q != 8'h00) || (len_q < MIN_LEN_W) || (len_q > max_len_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        xor_d       = xor_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_len_d  = last_len_q;
        max_len_d   = max_len_q;
        en_d        = en_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (en_q) begin
                        state_d = RECV;
                        len_d   = 16'd1;
                        xor_d   = rxd;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            RECV: begin
                // Once a frame is accepted it is checked to completion, even if en drops.
                if (rx_dv) begin
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    xor_d = xor_q ^ rxd;
                end else begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    err_d      = frame_bad;
                    last_len_d = len_q;
                    if (frame_bad) begin
                        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    end else begin
                        frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Evaluated after the frame update so a clear on the completion edge wins.
        if (wr_en) begin
            if (reg_off == OFF_MAX_LEN) begin
                max_len_d = bus_wr_data;
            end else if (reg_off == OFF_CTRL) begin
                en_d = bus_wr_data[0];
                if (bus_wr_data[1]) begin
                    frame_cnt_d = 16'h0000;
                    err_cnt_d   = 16'h0000;
                    last_len_d  = 16'h0000;
                end
            end
        end

        if (rd_en) begin
            unique case (reg_off)
                OFF_FRAME_CNT: rd_data_d = frame_cnt_q;
                OFF_ERR_CNT:   rd_data_d = err_cnt_q;
                OFF_LAST_LEN:  rd_data_d = last_len_q;
                OFF_MAX_LEN:   rd_data_d = max_len_q;
                OFF_CTRL:      rd_data_d = {15'h0000, en_q};
                default:       rd_data_d = 16'h0000;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= 16'h0000;
            xor_q       <= 8'h00;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
            last_len_q  <= 16'h0000;
            max_len_q   <= 16'd64;
            en_q        <= 1'b1;
            rd_data_q   <= 16'h0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            xor_q       <= xor_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_len_q  <= last_len_d;
            max_len_q   <= max_len_d;
            en_q        <= en_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_rd_data = rd_data_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_frame_monitor.sv
// Scoreboard bench for frame_monitor: directed scenarios plus randomized frames and
// register traffic, checked against a frame-level reference model.
module tb_frame_monitor;

    localparam logic [15:0] BASE    = 16'h0010;
    localparam int          MIN_LEN = 2;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        bus_cmd_valid;
    logic        bus_op;
    logic [15:0] bus_addr;
    logic [15:0] bus_wr_data;
    logic [15:0] bus_rd_data;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model state, updated at frame and register-transaction granularity.
    int  m_frame_cnt;
    int  m_err_cnt;
    int  m_last_len;
    int  m_max_len;
    bit  m_en;

    logic        frame_q[$];
    logic [15:0] rd_q[$];
    logic        rd_pending = 1'b0;

    frame_monitor #(.BASE_ADDR(BASE), .MIN_LEN(MIN_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_dv        (rx_dv),
        .bus_cmd_valid(bus_cmd_valid),
        .bus_op       (bus_op),
        .bus_addr     (bus_addr),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_frame_cnt = 0;
        m_err_cnt   = 0;
        m_last_len  = 0;
        m_max_len   = 64;
        m_en        = 1'b1;
    endtask

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        case (off)
            16'd0:   return 16'(m_frame_cnt);
            16'd1:   return 16'(m_err_cnt);
            16'd2:   return 16'(m_last_len);
            16'd3:   return 16'(m_max_len);
            16'd4:   return {15'h0000, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] off;
        off = a - BASE;
        if (off == 16'd3) m_max_len = int'(d);
        if (off == 16'd4) begin
            m_en = d[0];
            if (d[1]) begin
                m_frame_cnt = 0;
                m_err_cnt   = 0;
                m_last_len  = 0;
            end
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_cmd_valid = 1'b1;
        bus_op        = 1'b1;
        bus_addr      = a;
        bus_wr_data   = d;
        tick();
        model_write(a, d);
        bus_cmd_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        bus_cmd_valid = 1'b1;
        bus_op        = 1'b0;
        bus_addr      = a;
        rd_q.push_back(exp_read(a));
        tick();
        bus_cmd_valid = 1'b0;
    endtask

    // Sends one frame followed by exactly one idle cycle. An optional bus command can be
    // placed on the frame-end edge, and CTRL.en can be cleared during the second byte.
    task automatic send_frame(input byte_q_t bytes, input bit end_cmd, input bit end_op,
                              input logic [15:0] end_addr, input logic [15:0] end_data,
                              input bit mid_dis);
        bit         accepted;
        int         n;
        int         len;
        logic [7:0] x;
        bit         bad;
        accepted = m_en;
        n        = bytes.size();
        x        = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        for (int i = 0; i < n; i++) begin
            rx_dv = 1'b1;
            rxd   = bytes[i];
            if (mid_dis && i == 1) begin
                bus_cmd_valid = 1'b1;
                bus_op        = 1'b1;
                bus_addr      = BASE + 16'd4;
                bus_wr_data   = 16'h0000;
            end
            tick();
            if (mid_dis && i == 1) begin
                model_write(BASE + 16'd4, 16'h0000);
                bus_cmd_valid = 1'b0;
            end
        end
        rx_dv = 1'b0;
        rxd   = 8'h00;
        len   = (n > 65535) ? 65535 : n;
        bad   = (x != 8'h00) || (len < MIN_LEN) || (len > m_max_len);
        if (accepted) frame_q.push_back(bad);
        if (end_cmd) begin
            bus_cmd_valid = 1'b1;
            bus_op        = end_op;
            bus_addr      = end_addr;
            bus_wr_data   = end_data;
            if (!end_op) rd_q.push_back(exp_read(end_addr));
        end
        tick();
        if (accepted) begin
            if (bad) begin
                if (m_err_cnt < 65535) m_err_cnt++;
            end else begin
                if (m_frame_cnt < 65535) m_frame_cnt++;
            end
            m_last_len = len;
        end
        if (end_cmd && end_op) model_write(end_addr, end_data);
        bus_cmd_valid = 1'b0;
    endtask

    task automatic plain_frame(input byte_q_t bytes);
        send_frame(bytes, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 5; i++) bus_read(BASE + 16'(i));
    endtask

    // Monitor: compares read data and frame results whenever the DUT presents them.
    always @(posedge clk) rd_pending <= bus_cmd_valid && !bus_op;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (rd_q.size() == 0) check("rd_queue_empty", 32'(rd_q.size()), 32'd1);
            else check("bus_rd_data", 32'(bus_rd_data), 32'(rd_q.pop_front()));
        end
        if (frame_done) begin
            if (frame_q.size() == 0) check("frame_done_spurious", 32'(frame_done), 32'd0);
            else check("frame_err", 32'(frame_err), 32'(frame_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t    fr;
        logic [7:0] x;
        int         n;

        rst_n         = 1'b0;
        rxd           = 8'h00;
        rx_dv         = 1'b0;
        bus_cmd_valid = 1'b0;
        bus_op        = 1'b0;
        bus_addr      = 16'h0000;
        bus_wr_data   = 16'h0000;
        model_reset();
        #3;
        check("reset_rd_data", 32'(bus_rd_data), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        #4;
        rst_n = 1'b1;
        tick();
        read_all();

        // Good frame, then checksum error.
        plain_frame('{8'h11, 8'h22, 8'h33});
        bus_read(BASE + 16'd0);
        bus_read(BASE + 16'd2);
        plain_frame('{8'h11, 8'h22, 8'h34});
        bus_read(BASE + 16'd1);
        bus_read(BASE + 16'd0);

        // Length limits.
        plain_frame('{8'h00});
        bus_write(BASE + 16'd3, 16'd4);
        plain_frame('{8'h01, 8'h02, 8'h03, 8'h00, 8'h00});
        plain_frame('{8'h01, 8'h02, 8'h03, 8'h00});
        read_all();

        // Disabled monitor drops frames silently.
        bus_write(BASE + 16'd4, 16'h0000);
        plain_frame('{8'h11, 8'h22, 8'h33});
        read_all();
        bus_write(BASE + 16'd4, 16'h0001);

        // Clear on the frame-done edge wins; unmapped address reads zero.
        send_frame('{8'h11, 8'h22, 8'h33}, 1'b1, 1'b1, BASE + 16'd4, 16'h0003, 1'b0);
        read_all();
        bus_read(BASE + 16'd7);
        bus_read(16'h0000);

        // Read on the counter-update edge returns the old value; back-to-back frames.
        plain_frame('{8'h5A, 8'h5A});
        send_frame('{8'h01, 8'h01}, 1'b1, 1'b0, BASE + 16'd0, 16'h0000, 1'b0);
        send_frame('{8'h07}, 1'b1, 1'b0, BASE + 16'd2, 16'h0000, 1'b0);
        bus_read(BASE + 16'd0);
        bus_read(BASE + 16'd2);

        // Clearing en mid-frame keeps checking the frame already accepted.
        send_frame('{8'h0F, 8'hF0, 8'hFF}, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        read_all();
        plain_frame('{8'h11, 8'h11});
        bus_write(BASE + 16'd4, 16'h0001);

        // Randomized frames with interleaved register traffic.
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(1, 8);
            fr.delete();
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                fr.push_back(8'($urandom));
                x ^= fr[i];
            end
            if ($urandom_range(0, 2) != 0) fr[n-1] = fr[n-1] ^ x;
            plain_frame(fr);
            for (int j = 0, m = $urandom_range(0, 2); j < m; j++)
                bus_read(BASE + 16'($urandom_range(0, 6)));
            case ($urandom_range(0, 9))
                0: bus_write(BASE + 16'd3, 16'($urandom_range(2, 10)));
                1: bus_write(BASE + 16'd4, 16'($urandom_range(0, 3)));
                2: bus_write(BASE + 16'd4, 16'h0001);
                3: bus_write(BASE + 16'($urandom_range(0, 2)), 16'($urandom));
                default: ;
            endcase
            for (int j = 0, m = $urandom_range(0, 2); j < m; j++) tick();
        end
        bus_write(BASE + 16'd4, 16'h0001);
        read_all();

        // Reset in the middle of a frame.
        bus_read(BASE + 16'd3);
        rx_dv = 1'b1;
        rxd   = 8'h11;
        tick();
        rxd   = 8'h22;
        tick();
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        #2;
        check("midreset_rd_data", 32'(bus_rd_data), 32'd0);
        check("midreset_frame_done", 32'(frame_done), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        tick();
        check("post_reset_rd_data", 32'(bus_rd_data), 32'd0);
        read_all();
        plain_frame('{8'h11, 8'h22, 8'h33});
        read_all();

        tick();
        tick();
        check("frame_queue_drained", 32'(frame_q.size()), 32'd0);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
